// File: rtl/stage_fetch.sv
// Fetch stage: sequential PC issue to a 1-cycle-latency ROM, F/D latch with a
// 1-entry stall skid buffer, and redirect handling. Optional STAGE_FETCH_PERF_EN adds redirect_count.
module stage_fetch (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall,
   input  logic        j_took_branch,
   input  logic [31:0] pc_in,
   input  logic [31:0] q_imem,
   output logic [11:0] address_imem,
   output logic [31:0] insn_fd,
   output logic [31:0] pc_fd,
   output logic [4:0]  pc_upper_5,
   output logic        fd_valid,
   output logic        flush_dx
`ifdef STAGE_FETCH_PERF_EN
   ,
   output logic [15:0] redirect_count
`endif
);

   typedef enum logic [1:0] {BOOT, RUN, REFILL} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] issued_pc_q, issued_pc_d;
   logic        inflight_q, inflight_d;
   logic [31:0] insn_fd_q, insn_fd_d;
   logic [31:0] pc_fd_q, pc_fd_d;
   logic        fd_valid_q, fd_valid_d;
   logic        skid_valid_q, skid_valid_d;
   logic [31:0] skid_insn_q, skid_insn_d;
   logic [31:0] skid_pc_q, skid_pc_d;

   // inflight_q: q_imem this cycle is the word for issued_pc_q. A stall edge
   // re-reads the frozen fetch_pc, so that word is not tracked and gets re-fetched.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      issued_pc_d  = issued_pc_q;
      inflight_d   = inflight_q;
      insn_fd_d    = insn_fd_q;
      pc_fd_d      = pc_fd_q;
      fd_valid_d   = fd_valid_q;
      skid_valid_d = skid_valid_q;
      skid_insn_d  = skid_insn_q;
      skid_pc_d    = skid_pc_q;
      case (state_q)
         BOOT, REFILL: begin
            state_d     = RUN;
            fetch_pc_d  = fetch_pc_q + 32'd1;
            issued_pc_d = fetch_pc_q;
            inflight_d  = 1'b1;
         end
         RUN: begin
            if (stall) begin
               if (!skid_valid_q && inflight_q) begin
                  skid_valid_d = 1'b1;
                  skid_insn_d  = q_imem;
                  skid_pc_d    = issued_pc_q + 32'd1;
               end
               inflight_d = 1'b0;
            end else begin
               if (skid_valid_q) begin
                  insn_fd_d = skid_insn_q;
                  pc_fd_d   = skid_pc_q;
               end else begin
                  insn_fd_d = q_imem;
                  pc_fd_d   = issued_pc_q + 32'd1;
               end
               fd_valid_d   = skid_valid_q | inflight_q;
               skid_valid_d = 1'b0;
               fetch_pc_d   = fetch_pc_q + 32'd1;
               issued_pc_d  = fetch_pc_q;
               inflight_d   = 1'b1;
            end
         end
         default: state_d = BOOT;
      endcase
      // Redirect overrides everything above, including stall.
      if (j_took_branch && state_q != BOOT) begin
         state_d      = REFILL;
         fetch_pc_d   = pc_in;
         inflight_d   = 1'b0;
         insn_fd_d    = 32'd0;
         fd_valid_d   = 1'b0;
         skid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= BOOT;
         fetch_pc_q   <= 32'd0;
         issued_pc_q  <= 32'd0;
         inflight_q   <= 1'b0;
         insn_fd_q    <= 32'd0;
         pc_fd_q      <= 32'd0;
         fd_valid_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_insn_q  <= 32'd0;
         skid_pc_q    <= 32'd0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         issued_pc_q  <= issued_pc_d;
         inflight_q   <= inflight_d;
         insn_fd_q    <= insn_fd_d;
         pc_fd_q      <= pc_fd_d;
         fd_valid_q   <= fd_valid_d;
         skid_valid_q <= skid_valid_d;
         skid_insn_q  <= skid_insn_d;
         skid_pc_q    <= skid_pc_d;
      end
   end

   assign address_imem = fetch_pc_q[11:0];
   assign insn_fd      = insn_fd_q;
   assign pc_fd        = pc_fd_q;
   assign pc_upper_5   = pc_fd_q[31:27];
   assign fd_valid     = fd_valid_q;
   assign flush_dx     = j_took_branch & reset;

`ifdef STAGE_FETCH_PERF_EN
   logic [15:0] redirect_count_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         redirect_count_q <= 16'd0;
      end else if (j_took_branch && redirect_count_q != 16'hFFFF) begin
         redirect_count_q <= redirect_count_q + 16'd1;
      end
   end

   assign redirect_count = redirect_count_q;
`endif

endmodule

// File: tb/tb_stage_fetch.sv
// Bench for stage_fetch: synchronous ROM model, per-cycle vector table and
// an in-order expected-instruction queue.
module tb_stage_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        j_took_branch;
  logic [31:0] pc_in;
  logic [31:0] q_imem;
  logic [11:0] address_imem;
  logic [31:0] insn_fd;
  logic [31:0] pc_fd;
  logic [4:0]  pc_upper_5;
  logic        fd_valid;
  logic        flush_dx;
`ifdef STAGE_FETCH_PERF_EN
  logic [15:0] redirect_count;
`endif

  stage_fetch dut (
    .clock         (clock),
    .reset         (reset),
    .stall         (stall),
    .j_took_branch (j_took_branch),
    .pc_in         (pc_in),
    .q_imem        (q_imem),
    .address_imem  (address_imem),
    .insn_fd       (insn_fd),
    .pc_fd         (pc_fd),
    .pc_upper_5    (pc_upper_5),
    .fd_valid      (fd_valid),
    .flush_dx      (flush_dx)
`ifdef STAGE_FETCH_PERF_EN
    ,
    .redirect_count(redirect_count)
`endif
  );

  // clock / reset block and ROM model
  always #5 clock = ~clock;

  logic [31:0] rom [0:4095];
  always @(posedge clock) q_imem <= rom[address_imem];

  // scoreboard state: each entry is {pc_fd, insn_fd}
  logic [63:0] exp_q[$];
  logic [63:0] prev_exp;
  logic [15:0] perf_exp;
  int          tot = 0;
  int          bad = 0;

  typedef struct packed {
    logic        s;
    logic        jj;
    logic [31:0] tgt;
    logic        ev;
  } vec_t;
  vec_t vecs [23];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tot++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push_stream(input logic [31:0] t);
    logic [31:0] a;
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      a = t + k;
      exp_q.push_back({a + 32'd1, rom[a[11:0]]});
    end
  endtask

  // driver: one clock per call; called just after a falling edge
  task automatic step(input logic s, input logic jj, input logic [31:0] t, input logic ev);
    logic [63:0] e;
    stall = s;
    j_took_branch = jj;
    pc_in = t;
    #1 chk("flush_dx", {63'd0, flush_dx}, {63'd0, jj});
    if (jj) push_stream(t);
    @(posedge clock);
    if (jj && perf_exp != 16'hFFFF) perf_exp++;
    @(negedge clock);
    chk("fd_valid", {63'd0, fd_valid}, {63'd0, ev});
    if (fd_valid === 1'b1) begin
      if (s && !jj) begin
        chk("hold_insn", {32'd0, insn_fd}, {32'd0, prev_exp[31:0]});
        chk("hold_pc", {32'd0, pc_fd}, {32'd0, prev_exp[63:32]});
      end else if (exp_q.size() == 0) begin
        tot++;
        bad++;
        $display("FAIL sb_empty: got insn %0h pc %0h expected none queued", insn_fd, pc_fd);
      end else begin
        e = exp_q.pop_front();
        prev_exp = e;
        chk("insn_fd", {32'd0, insn_fd}, {32'd0, e[31:0]});
        chk("pc_fd", {32'd0, pc_fd}, {32'd0, e[63:32]});
        chk("pc_upper_5", {59'd0, pc_upper_5}, {59'd0, e[63:59]});
      end
    end else begin
      chk("insn_nop", {32'd0, insn_fd}, 64'd0);
    end
`ifdef STAGE_FETCH_PERF_EN
    chk("redirect_count", {48'd0, redirect_count}, {48'd0, perf_exp});
`endif
  endtask

  // async reset with j_took_branch held high to prove flush_dx is masked
  task automatic do_reset();
    reset = 1'b0;
    stall = 1'b0;
    j_took_branch = 1'b1;
    pc_in = 32'h0000_0ABC;
    #1;
    chk("rst_fd_valid", {63'd0, fd_valid}, 64'd0);
    chk("rst_insn_fd", {32'd0, insn_fd}, 64'd0);
    chk("rst_pc_fd", {32'd0, pc_fd}, 64'd0);
    chk("rst_addr", {52'd0, address_imem}, 64'd0);
    chk("rst_flush_dx", {63'd0, flush_dx}, 64'd0);
`ifdef STAGE_FETCH_PERF_EN
    chk("rst_redirect_count", {48'd0, redirect_count}, 64'd0);
`endif
    perf_exp = 16'd0;
    push_stream(32'd0);
    j_took_branch = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    // BOOT edge, then ROM[0] and ROM[1] on consecutive edges
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] salt;
    salt = $urandom_range(32'h0000_0001, 32'h00FF_FFFF);
    for (int i = 0; i < 4096; i++) rom[i] = {8'hC3, salt[23:0]} ^ (i * 32'h0001_0003);

    // cycle-by-cycle table starting at the BOOT edge after reset release
    vecs[0]  = '{1'b0, 1'b0, 32'h0,  1'b0};  // BOOT
    vecs[1]  = '{1'b0, 1'b0, 32'h0,  1'b1};  // A
    vecs[2]  = '{1'b0, 1'b0, 32'h0,  1'b1};  // B
    vecs[3]  = '{1'b1, 1'b0, 32'h0,  1'b1};  // stall, B held
    vecs[4]  = '{1'b1, 1'b0, 32'h0,  1'b1};  // stall, B held
    vecs[5]  = '{1'b0, 1'b0, 32'h0,  1'b1};  // C from skid
    vecs[6]  = '{1'b0, 1'b0, 32'h0,  1'b1};  // D
    vecs[7]  = '{1'b0, 1'b1, 32'h40, 1'b0};  // redirect 0x40
    vecs[8]  = '{1'b0, 1'b0, 32'h0,  1'b0};  // REFILL
    vecs[9]  = '{1'b0, 1'b0, 32'h0,  1'b1};  // ROM[0x40]
    vecs[10] = '{1'b0, 1'b0, 32'h0,  1'b1};
    vecs[11] = '{1'b1, 1'b0, 32'h0,  1'b1};  // stall fills skid
    vecs[12] = '{1'b1, 1'b1, 32'h10, 1'b0};  // stall+redirect: redirect wins
    vecs[13] = '{1'b0, 1'b0, 32'h0,  1'b0};
    vecs[14] = '{1'b0, 1'b0, 32'h0,  1'b1};  // ROM[0x10]
    vecs[15] = '{1'b0, 1'b1, 32'h80, 1'b0};  // redirect 0x80
    vecs[16] = '{1'b0, 1'b1, 32'h20, 1'b0};  // re-redirect in REFILL
    vecs[17] = '{1'b0, 1'b0, 32'h0,  1'b0};
    vecs[18] = '{1'b0, 1'b0, 32'h0,  1'b1};  // ROM[0x20]
    vecs[19] = '{1'b0, 1'b0, 32'h0,  1'b1};
    vecs[20] = '{1'b1, 1'b0, 32'h0,  1'b1};
    vecs[21] = '{1'b0, 1'b0, 32'h0,  1'b1};
    vecs[22] = '{1'b0, 1'b0, 32'h0,  1'b1};

    reset = 1'b1;
    stall = 1'b0;
    j_took_branch = 1'b0;
    pc_in = 32'd0;
    perf_exp = 16'd0;
    prev_exp = 64'd0;
    @(negedge clock);

    // table run from a fresh reset
    reset = 1'b0;
    #1;
    push_stream(32'd0);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 23; i++) step(vecs[i].s, vecs[i].jj, vecs[i].tgt, vecs[i].ev);

    // address wrap 4095->0 with upper PC bits carried into pc_fd
    step(1'b0, 1'b1, 32'h8000_0FFE, 1'b0);
    chk("addr_after_redirect", {52'd0, address_imem}, 64'hFFE);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    chk("addr_refill", {52'd0, address_imem}, 64'hFFF);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    chk("addr_wrap", {52'd0, address_imem}, 64'h000);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);

    // full 32-bit PC wrap
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);

    // reset mid-stall with the skid full
    step(1'b1, 1'b0, 32'd0, 1'b1);
    do_reset();

    // reset mid-REFILL
    step(1'b0, 1'b1, 32'h300, 1'b0);
    do_reset();

    // three redirects back to back, then delivery from the last target
    step(1'b0, 1'b1, 32'h100, 1'b0);
    step(1'b0, 1'b1, 32'h200, 1'b0);
    step(1'b0, 1'b1, 32'h180, 1'b0);
`ifdef STAGE_FETCH_PERF_EN
    chk("redirect_count_3", {48'd0, redirect_count}, 64'd3);
`endif
    step(1'b0, 1'b0, 32'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1);
    step(1'b1, 1'b0, 32'd0, 1'b1);
    step(1'b0, 1'b0, 32'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/stage_fetch.md
STAGE_FETCH -- requirements
Module: stage_fetch

Interface
REQ-001 SHALL have port `clock`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port `stall`, input, 1 bit: hazard-unit hold of the F/D latch.
REQ-004 SHALL have port `j_took_branch`, input, 1 bit: redirect request from execute.
REQ-005 SHALL have port `pc_in`, input, 32 bits: redirect target, sampled when `j_took_branch`=1.
REQ-006 SHALL have port `q_imem`, input, 32 bits: instruction ROM data, valid one cycle after the address is presented.
REQ-007 SHALL have port `address_imem`, output, 12 bits: ROM address, equal to fetch_pc[11:0].
REQ-008 SHALL have port `insn_fd`, output, 32 bits: F/D instruction; 32'd0 (nop) when invalid.
REQ-009 SHALL have port `pc_fd`, output, 32 bits: fetched-instruction PC+1, consumed as the execute `pc_out`.
REQ-010 SHALL have port `pc_upper_5`, output, 5 bits: equal to `pc_fd`[31:27].
REQ-011 SHALL have port `fd_valid`, output, 1 bit: F/D holds a real instruction.
REQ-012 SHALL have port `flush_dx`, output, 1 bit: squashes the D/X latch this cycle.

Function
REQ-013 SHALL hold a 32-bit fetch_pc register and a 3-state FSM: BOOT, RUN, REFILL.
REQ-014 In BOOT, the block SHALL present fetch_pc=0, keep `fd_valid`=0, and move to RUN on the next edge.
REQ-015 In RUN with `stall`=0 and `j_took_branch`=0, each edge SHALL do all of the following:
- latch `q_imem` into `insn_fd`;
- latch (issued PC + 1) into `pc_fd`;
- set `fd_valid`=1;
- increment fetch_pc by 1, wrapping mod 2^32.
REQ-016 On `stall`=1 without redirect, the block SHALL freeze fetch_pc, `insn_fd`, `pc_fd` and `fd_valid`.
REQ-017 On `stall`=1 without redirect, the ROM word returning during the stall SHALL be captured in a 1-entry skid register (insn + PC).
REQ-018 On the first non-stalled edge, F/D SHALL load from the skid register if it is valid, otherwise from `q_imem`; no instruction is dropped or duplicated.
REQ-019 On `j_took_branch`=1 (any state except BOOT), the edge SHALL do all of the following:
- set fetch_pc=`pc_in`;
- clear `fd_valid` and the skid register;
- force `insn_fd`=0;
- enter REFILL.
REQ-020 `flush_dx` SHALL equal `j_took_branch` combinationally in the same cycle.
REQ-021 REFILL SHALL last exactly one cycle with `fd_valid`=0, waiting for ROM data at `pc_in`, then return to RUN.
REQ-022 Redirect SHALL take priority over `stall` in the same cycle.
REQ-023 A redirect during REFILL SHALL restart REFILL with the new target.
REQ-024 Branch penalty SHALL be 2 bubbles: the D/X flush plus the REFILL cycle.
REQ-025 `address_imem` SHALL wrap 4095->0.
REQ-026 fetch_pc upper bits SHALL propagate unmodified into `pc_fd`.

Reset
REQ-027 While `reset`=0, the block SHALL asynchronously set:
- fetch_pc=0;
- FSM=BOOT;
- `insn_fd`=0, `pc_fd`=0, `fd_valid`=0;
- skid register empty;
- the performance counter=0.
REQ-028 `flush_dx` SHALL be 0 while in reset.
REQ-029 Reset asserted mid-stall or mid-REFILL SHALL discard all pending state.
REQ-030 After reset is released, the first edge SHALL enter BOOT behaviour; the insn at address 0 SHALL appear on `insn_fd` two edges after release.

Configuration
REQ-031 With macro STAGE_FETCH_PERF_EN defined, the block SHALL add output `redirect_count` (16 bits).
REQ-032 `redirect_count` SHALL increment on every edge with `j_took_branch`=1, saturate at 16'hFFFF, and reset to 0.
REQ-033 Without STAGE_FETCH_PERF_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Scenario, reset release: ROM[0..2]=A,B,C -> `fd_valid` rises at edge 2; `insn_fd`=A,B,C on consecutive edges; `pc_fd`=1,2,3.
REQ-035 Scenario, 2-cycle stall: `stall` high for 2 cycles while `insn_fd`=B -> `insn_fd` stays B; then C, then D; no gap, no repeat.
REQ-036 Scenario, redirect: `j_took_branch`=1, `pc_in`=0x40 -> `flush_dx`=1 same cycle; 2 cycles `fd_valid`=0; then `insn_fd`=ROM[0x40], `pc_fd`=0x41.
REQ-037 Scenario, stall+redirect: `stall`=1 and `j_took_branch`=1, `pc_in`=0x10 -> redirect wins; skid is cleared; ROM[0x10] is delivered after REFILL.
REQ-038 Scenario, back-to-back redirects: redirect to 0x20 in REFILL after redirect to 0x80 -> only ROM[0x20] appears; ROM[0x80] is never valid.
REQ-039 Scenario, wrap and perf: fetch_pc=0x00000FFF -> `address_imem` becomes 0; with STAGE_FETCH_PERF_EN, 3 redirects -> `redirect_count`=3.
